spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 7 +
 rtl/spi_sync.sv | 16 +
 rtl/spi_slave.sv | 100 ++++++++++
 tb/tb_spi_slave.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI state encoding, word width and idle line levels.
package spi_pkg;
    localparam int SPI_WIDTH = 8;
    localparam logic SCLK_IDLE = 1'b1;
    localparam logic SS_IDLE = 1'b1;
    typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: N-stage flop synchronizer with selectable reset value.
module spi_sync #(
    parameter int N = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [N-1:0] r;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r <= {N{RST_VAL}};
        else r <= {r[N-2:0], d};
    assign q = r[N-1];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave (sample on sclk rise, shift on fall, MSB first).
// Define SPI_SLAVE_MISO_OE_EN to add a miso_oe output for an external tri-state buffer.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 ss,
    input  logic                 mosi,
    output logic                 miso,
    input  logic [SPI_WIDTH-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [SPI_WIDTH-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy
`ifdef SPI_SLAVE_MISO_OE_EN
    ,
    output logic                 miso_oe
`endif
);
    localparam logic [$clog2(SPI_WIDTH)-1:0] LAST = ($clog2(SPI_WIDTH))'(SPI_WIDTH - 1);
    logic sclk_s, ss_s, mosi_s, sclk_d, ss_d;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise, load;
    state_t state;
    logic [SPI_WIDTH-1:0] tx_shift, rx_shift, tx_buf, next_tx, rx_next;
    logic tx_full;
    logic [$clog2(SPI_WIDTH)-1:0] bit_cnt;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(SS_IDLE))   u_ss   (.clk(clk), .rst_n(rst_n), .d(ss),   .q(ss_s));
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0))      u_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall = ~ss_s & ss_d;
    assign ss_rise = ss_s & ~ss_d;
    assign tx_ready = ~tx_full;
    assign busy = (state == SHIFT);
    assign rx_next = {rx_shift[SPI_WIDTH-2:0], mosi_s};
    // An empty buffer lets a byte offered on the load cycle go straight into tx_shift.
    assign next_tx = tx_full ? tx_buf : (tx_valid ? tx_data : '0);
    assign load = (state == IDLE) ? ss_fall : (!ss_rise && sclk_rise && bit_cnt == '0);
`ifdef SPI_SLAVE_MISO_OE_EN
    assign miso_oe = (state == SHIFT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d   <= SCLK_IDLE;
            ss_d     <= SS_IDLE;
            state    <= IDLE;
            miso     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_full  <= 1'b0;
            tx_buf   <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= LAST;
        end else begin
            sclk_d   <= sclk_s;
            ss_d     <= ss_s;
            rx_valid <= 1'b0;
            if (load) tx_full <= 1'b0;
            else if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
            if (state == IDLE) begin
                if (ss_fall) begin
                    state    <= SHIFT;
                    tx_shift <= next_tx;
                    miso     <= next_tx[SPI_WIDTH-1];
                    bit_cnt  <= LAST;
                end
            end else if (ss_rise) begin
                state    <= IDLE;
                miso     <= 1'b0;
                bit_cnt  <= LAST;
                rx_shift <= '0;
            end else if (sclk_rise) begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt - 1'b1;
                if (bit_cnt == '0) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                    tx_shift <= next_tx;
                end else begin
                    tx_shift <= {tx_shift[SPI_WIDTH-2:0], 1'b0};
                end
            end else if (sclk_fall) begin
                miso <= tx_shift[SPI_WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized SPI master against a byte-level model of the slave.
module tb_spi_slave;
    localparam int HP = 60;
    localparam int SYNC_STAGES = 2;
    logic clk = 0, rst_n = 0, sclk = 1, ss = 1, mosi = 0, tx_valid = 0;
    logic [7:0] tx_data = 0;
    logic miso, tx_ready, rx_valid, busy;
    logic [7:0] rx_data;
`ifdef SPI_SLAVE_MISO_OE_EN
    logic miso_oe;
`endif
    int total = 0, bad = 0;
    logic [7:0] expq[$], rxq[$];
    logic [7:0] f_mo[4], f_ob[4];
    logic f_off[4];

    spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_MISO_OE_EN
        , .miso_oe(miso_oe)
`endif
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (rst_n && rx_valid) rxq.push_back(rx_data);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Offer a byte and record it in the model once the handshake completes.
    task automatic offer(input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        tx_data = d;
        tx_valid = 1;
        while (!tx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) chk("offer_timeout", 0, 1);
        else begin
            @(posedge clk);
            expq.push_back(d);
        end
        #1 tx_valid = 0;
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 0;
        for (int i = 7; i > 7 - nbits; i--) begin
            sclk = 0;
            mosi = mo[i];
            #HP;
            mi[i] = miso;
            sclk = 1;
            #HP;
        end
    endtask

    task automatic frame(input int n);
        logic [7:0] mi, want, m, b;
        logic o;
        rxq.delete();
        if (f_off[0]) offer(f_ob[0]);
        ss = 0;
        #(2 * HP);
        chk("busy_sel", busy, 1);
`ifdef SPI_SLAVE_MISO_OE_EN
        chk("oe_sel", miso_oe, 1);
`endif
        for (int k = 0; k < n; k++) begin
            want = expq.size() > 0 ? expq.pop_front() : 8'h00;
            m = f_mo[k];
            o = (k + 1 < n) && f_off[k + 1];
            b = f_ob[k + 1 < 4 ? k + 1 : 0];
            fork
                xfer(m, 8, mi);
                begin
                    if (o) begin
                        #80;
                        offer(b);
                    end
                end
            join
            chk("miso_byte", mi, want);
        end
        ss = 1;
`ifdef SPI_SLAVE_MISO_OE_EN
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1 chk("oe_off", miso_oe, 0);
`endif
        #(2 * HP);
        chk("rx_count", rxq.size(), n);
        for (int k = 0; k < n; k++) chk("rx_byte", k < rxq.size() ? rxq[k] : 8'hxx, f_mo[k]);
        chk("busy_idle", busy, 0);
        chk("miso_idle", miso, 0);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mi, saved;
        int n;
        #22;
        chk("rst_miso", miso, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 1);
`ifdef SPI_SLAVE_MISO_OE_EN
        chk("rst_oe", miso_oe, 0);
`endif
        rst_n = 1;
        #50;
        f_mo[0] = 8'hA5; f_off[0] = 1; f_ob[0] = 8'hC3;
        frame(1);
        f_mo[0] = 8'h0F; f_mo[1] = 8'hF0; f_off[0] = 1; f_off[1] = 1; f_ob[0] = 8'h12; f_ob[1] = 8'h34;
        frame(2);
        f_mo[0] = 8'h5A; f_off[0] = 0; f_off[1] = 0;
        frame(1);
        // Abort after four bits.
        saved = rx_data;
        rxq.delete();
        ss = 0;
        #(2 * HP);
        xfer(8'hFF, 4, mi);
        #HP;
        ss = 1;
        #120;
        chk("abort_no_valid", rxq.size(), 0);
        chk("abort_rx_hold", rx_data, saved);
        chk("abort_busy", busy, 0);
        f_mo[0] = 8'h81;
        frame(1);
        // Reset mid-byte with a byte waiting in the buffer.
        ss = 0;
        #(2 * HP);
        offer(8'h77);
        chk("buf_full", tx_ready, 0);
        xfer(8'hAA, 4, mi);
        #(HP / 2);
        rst_n = 0;
        #1;
        chk("mid_rst_miso", miso, 0);
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_ready", tx_ready, 1);
`ifdef SPI_SLAVE_MISO_OE_EN
        chk("mid_rst_oe", miso_oe, 0);
`endif
        expq.delete();
        ss = 1;
        sclk = 1;
        #20 rst_n = 1;
        #40;
        f_mo[0] = 8'h3C; f_off[0] = 0;
        frame(1);
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) begin
                f_mo[k] = 8'($urandom);
                f_ob[k] = 8'($urandom);
                f_off[k] = 1'($urandom);
            end
            frame(n);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
